// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters.
// A two-way round-robin arbiter grants one operation at a time. The opcode
// and operands are registered onto the ALU ports, and the ALU result and
// flags are registered one cycle later. The result is held until the owning
// requester acknowledges it.

package cpu_types_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

module alu_share_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    // requester side
    input  logic [1:0]  req_valid,
    input  aluop_t      req_aluop0,
    input  aluop_t      req_aluop1,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_b1,
    output logic [1:0]  req_ready,
    // ALU side
    output aluop_t      alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    // response side
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_zero,
    output logic        resp_neg,
    output logic        resp_ovf,
    input  logic [1:0]  resp_ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    aluop_t      op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_zero_q, resp_zero_d;
    logic        resp_neg_q, resp_neg_d;
    logic        resp_ovf_q, resp_ovf_d;

    logic        grant_valid;
    logic        grant_idx;

    // Round-robin pick: a lone requester wins; under contention the one not granted last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_idx   = ~last_grant_q;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = 1'b0;
            end
        endcase
    end

    // Next-state logic: accept in IDLE, capture the ALU result in EXEC, wait for the owner's ack in RESP.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        resp_data_d  = resp_data_q;
        resp_zero_d  = resp_zero_q;
        resp_neg_d   = resp_neg_q;
        resp_ovf_d   = resp_ovf_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    op_d         = grant_idx ? req_aluop1 : req_aluop0;
                    a_d          = grant_idx ? req_a1 : req_a0;
                    b_d          = grant_idx ? req_b1 : req_b0;
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp_data_d = alu_out;
                resp_zero_d = alu_zero;
                resp_neg_d  = alu_neg;
                resp_ovf_d  = alu_ovf;
                state_d     = RESP;
            end
            RESP: begin
                // An ack from the other requester is not for this response.
                if (resp_ack[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            op_q         <= ALU_SLL;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            resp_data_q  <= 32'd0;
            resp_zero_q  <= 1'b0;
            resp_neg_q   <= 1'b0;
            resp_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            resp_data_q  <= resp_data_d;
            resp_zero_q  <= resp_zero_d;
            resp_neg_q   <= resp_neg_d;
            resp_ovf_q   <= resp_ovf_d;
        end
    end

    // Per-requester handshake decode. Ready is gated by nRST so nothing is
    // accepted while reset is held, even though the state already reads IDLE.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_ready[gi]  = nRST && (state_q == IDLE) && grant_valid && (grant_idx == 1'(gi));
        assign resp_valid[gi] = (state_q == RESP) && (owner_q == 1'(gi));
    end

    // ALU inputs come straight from the operand registers in every state.
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;

    assign resp_data = resp_data_q;
    assign resp_zero = resp_zero_q;
    assign resp_neg  = resp_neg_q;
    assign resp_ovf  = resp_ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural ALU sits behind the DUT, a
// transaction-level model predicts every output each cycle, and directed
// sequences pin the model with hand-computed values.
module tb_alu_share_ctrl;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  req_valid;
    aluop_t      req_aluop0, req_aluop1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [1:0]  req_ready;
    aluop_t      alu_op;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_zero, alu_neg, alu_ovf;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_zero, resp_neg, resp_ovf;
    logic [1:0]  resp_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 CLK = ~CLK;

    alu_share_ctrl dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req_valid  (req_valid),
        .req_aluop0 (req_aluop0),
        .req_aluop1 (req_aluop1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .req_ready  (req_ready),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .alu_ovf    (alu_ovf),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_neg   (resp_neg),
        .resp_ovf   (resp_ovf),
        .resp_ack   (resp_ack),
        .busy       (busy)
    );

    // Behavioural ALU: returns {zero, negative, overflow, result}.
    function automatic logic [34:0] alu_model(aluop_t op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = 32'd0;
        v = 1'b0;
        case (op)
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_ADD: begin
                r = a + b;
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_SUB: begin
                r = a - b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            default:  r = 32'd0;
        endcase
        return {(r == 32'd0), r[31], v, r};
    endfunction

    assign {alu_zero, alu_neg, alu_ovf, alu_out} = alu_model(alu_op, alu_a, alu_b);

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Arbitration rule: -1 none, else winning requester index.
    function automatic int pick(logic [1:0] v, logic last);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (v == 2'b11) return last ? 0 : 1;
        return -1;
    endfunction

    // Transaction model: one operation in flight, owner, operands, accept cycle.
    logic   m_pending = 1'b0;
    logic   m_owner   = 1'b0;
    logic   m_last    = 1'b1;
    aluop_t m_op      = ALU_SLL;
    logic [31:0] m_a  = 32'd0;
    logic [31:0] m_b  = 32'd0;
    int     cyc       = 0;
    int     m_acc     = 0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_pending <= 1'b0;
            m_owner   <= 1'b0;
            m_last    <= 1'b1;
            m_op      <= ALU_SLL;
            m_a       <= 32'd0;
            m_b       <= 32'd0;
            cyc       <= 0;
            m_acc     <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_pending) begin
                if (cyc >= m_acc + 1 && resp_ack[m_owner]) m_pending <= 1'b0;
            end else if (pick(req_valid, m_last) >= 0) begin
                m_pending <= 1'b1;
                m_owner   <= (pick(req_valid, m_last) == 1);
                m_last    <= (pick(req_valid, m_last) == 1);
                m_op      <= (pick(req_valid, m_last) == 1) ? req_aluop1 : req_aluop0;
                m_a       <= (pick(req_valid, m_last) == 1) ? req_a1 : req_a0;
                m_b       <= (pick(req_valid, m_last) == 1) ? req_b1 : req_b0;
                m_acc     <= cyc + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        int          g;
        logic [1:0]  e_ready;
        logic [1:0]  e_rv;
        logic [34:0] e_res;
        if (cmp_en) begin
            g       = pick(req_valid, m_last);
            e_ready = (nRST && !m_pending && g >= 0) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
            e_rv    = (m_pending && cyc >= m_acc + 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("busy", 32'(busy), 32'(m_pending));
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            if (e_rv != 2'b00) begin
                e_res = alu_model(m_op, m_a, m_b);
                chk("resp_data", resp_data, e_res[31:0]);
                chk("resp_flags", 32'({resp_zero, resp_neg, resp_ovf}), 32'(e_res[34:32]));
            end
        end
    end

    task automatic set_req(input int idx, input aluop_t op, input logic [31:0] a, input logic [31:0] b);
        if (idx == 0) begin
            req_aluop0 = op;
            req_a0     = a;
            req_b0     = b;
            req_valid[0] = 1'b1;
        end else begin
            req_aluop1 = op;
            req_a1     = a;
            req_b1     = b;
            req_valid[1] = 1'b1;
        end
    endtask

    // Wait (bounded) at negedges until req_ready[idx]; the transfer happens on the next posedge.
    task automatic wait_ready(input int idx, input string nm);
        int n;
        n = 0;
        @(negedge CLK);
        while (!req_ready[idx] && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_accept"}, 32'(req_ready), (idx == 1) ? 32'd2 : 32'd1);
    endtask

    // Wait (bounded) at negedges for resp_valid of idx; returns negedges waited beyond the first.
    task automatic wait_resp(input int idx, output int n);
        n = 0;
        @(negedge CLK);
        while (resp_valid !== ((idx == 1) ? 2'b10 : 2'b01) && n < 20) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic run_op(input int idx, input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic ez, input logic en, input logic eo,
                          input string nm);
        int n;
        set_req(idx, op, a, b);
        wait_ready(idx, nm);
        @(posedge CLK);
        #1 req_valid[idx] = 1'b0;
        wait_resp(idx, n);
        chk({nm, "_latency"}, 32'(n), 32'd1);
        chk({nm, "_resp_valid"}, 32'(resp_valid), (idx == 1) ? 32'd2 : 32'd1);
        chk({nm, "_data"}, resp_data, ed);
        chk({nm, "_flags"}, 32'({resp_zero, resp_neg, resp_ovf}), 32'({ez, en, eo}));
        $display("op req%0d %s a=%h b=%h -> data=%h z=%0d n=%0d v=%0d",
                 idx, nm, a, b, resp_data, resp_zero, resp_neg, resp_ovf);
        resp_ack[idx] = 1'b1;
        @(posedge CLK);
        #1 resp_ack = 2'b00;
    endtask

    int rr_g[$];
    int rr_c[$];
    int n_wait;

    initial begin
        nRST       = 1'b0;
        req_valid  = 2'b11;
        req_aluop0 = ALU_ADD;
        req_aluop1 = ALU_SUB;
        req_a0     = 32'h11;
        req_b0     = 32'h22;
        req_a1     = 32'h33;
        req_b1     = 32'h44;
        resp_ack   = 2'b00;
        #2 cmp_en  = 1'b1;

        // Reset held with both requests pending.
        repeat (3) @(negedge CLK);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        req_valid = 2'b00;
        @(posedge CLK);
        #1 nRST = 1'b1;

        // Single operations and flag cases.
        run_op(0, ALU_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0, "add");
        run_op(0, ALU_SUB, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b0, 1'b0, "sub_zero");
        run_op(1, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b1, "add_ovf");

        // Round-robin under continuous contention with immediate ack.
        set_req(0, ALU_ADD, 32'd100, 32'd1);
        set_req(1, ALU_SUB, 32'd50, 32'd8);
        resp_ack = 2'b11;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            if ((req_valid & req_ready) != 2'b00) begin
                rr_g.push_back(int'(req_ready[1]));
                rr_c.push_back(i);
                $display("grant req%0d at step %0d", req_ready[1], i);
            end
        end
        req_valid = 2'b00;
        repeat (4) @(negedge CLK);
        resp_ack = 2'b00;
        chk("rr_count", 32'(rr_g.size()), 32'd5);
        if (rr_g.size() >= 4) begin
            chk("rr_g0", 32'(rr_g[0]), 32'd0);
            chk("rr_g1", 32'(rr_g[1]), 32'd1);
            chk("rr_g2", 32'(rr_g[2]), 32'd0);
            chk("rr_g3", 32'(rr_g[3]), 32'd1);
            chk("rr_space", 32'(rr_c[3] - rr_c[0]), 32'd9);
        end

        // Backpressure on requester 0 while requester 1 waits and changes its operands.
        @(posedge CLK);
        #1 set_req(0, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        wait_ready(0, "bp");
        @(posedge CLK);
        #1 req_valid[0] = 1'b0;
        set_req(1, ALU_ADD, 32'd1, 32'd1);
        wait_resp(0, n_wait);
        chk("bp_latency", 32'(n_wait), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                req_a1 = 32'd10;
                req_b1 = 32'd20;
            end
            if (i == 6) resp_ack = 2'b10;
            if (i == 7) resp_ack = 2'b00;
            @(negedge CLK);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_data", resp_data, 32'h0000_F000);
        end
        $display("op req0 and held 10 cycles -> data=%h", resp_data);
        resp_ack = 2'b01;
        @(posedge CLK);
        #1 resp_ack = 2'b00;
        @(negedge CLK);
        chk("bp_release_valid", 32'(resp_valid), 32'd0);
        chk("bp_next_ready", 32'(req_ready), 32'd2);
        @(posedge CLK);
        #1 req_valid[1] = 1'b0;
        wait_resp(1, n_wait);
        chk("chg_latency", 32'(n_wait), 32'd1);
        chk("chg_data", resp_data, 32'd30);
        $display("op req1 add changed operands -> data=%h", resp_data);
        resp_ack = 2'b10;
        @(posedge CLK);
        #1 resp_ack = 2'b00;

        // Asynchronous reset in the middle of EXEC.
        set_req(0, ALU_ADD, 32'd9, 32'd9);
        wait_ready(0, "arst");
        @(posedge CLK);
        #1 req_valid[0] = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_alu_a", alu_a, 32'd0);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1 nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("arst_no_resp", 32'(resp_valid), 32'd0);
            chk("arst_idle", 32'(busy), 32'd0);
        end
        $display("op req0 add discarded by reset");

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
